// File: rtl/mac_pkg.sv
// Shared types and the shift-and-saturate helper for the MAC result path.
// Holds the MAC widths, the result type, the buffer entry layout and sat_shift().
package mac_pkg;

    localparam int MAC_IN_W  = 11;
    localparam int MAC_OUT_W = 8;

    typedef logic signed [MAC_IN_W-1:0] mac_result_t;

    typedef struct packed {
        logic                        sat;
        logic signed [MAC_OUT_W-1:0] data;
    } buf_entry_t;

    // Wide result of sat_shift(); callers keep the low out_w bits of val.
    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } sat_res_t;

    // Arithmetic right shift, optional clamp of negatives to zero, then
    // saturation to an out_w-bit signed range.
    function automatic sat_res_t sat_shift(
        input logic signed [31:0] x,
        input int                 shift,
        input int                 out_w,
        input logic               relu
    );
        logic signed [31:0] s;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sat_res_t           r;
        s  = x >>> shift;
        if (relu && (s < 0)) begin
            s = '0;
        end
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        r.sat = 1'b0;
        r.val = s;
        if (s > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_result_buffer_fifo.sv
// sync_fifo_fwft: generic first-word-fall-through FIFO with count/full/empty.
// Ports: clk, reset (sync, active-high), push/din, pop, dout/valid, count, full, empty.
module sync_fifo_fwft #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  last_q, last_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign valid = !empty;
    assign count = count_q;
    // With nothing stored, show the last entry that left (or reset value).
    assign dout  = empty ? last_q : mem_q[rptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        // A pop on the same edge frees the slot a full-FIFO push needs.
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        last_d  = last_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            last_d = mem_q[rptr_q];
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Storage is only ever read behind the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mac_result_buffer.sv
// MAC result buffer: shifts/saturates each MAC result and queues it in a FWFT FIFO.
// Ports: clk, reset, in_valid/in_data, out_valid/out_ready/out_data/out_sat,
// count, full, empty, overflow (sticky drop). Option: MAC_RESULT_BUFFER_RELU_EN.
module mac_result_buffer
    import mac_pkg::*;
#(
    parameter int IN_W  = MAC_IN_W,
    parameter int OUT_W = MAC_OUT_W,
    parameter int SHIFT = 0,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_sat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);

`ifdef MAC_RESULT_BUFFER_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    logic signed [31:0] in_ext;
    sat_res_t           cond;
    logic               unused_hi;

    logic               s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]   s1_data_q, s1_data_d;
    logic               s1_sat_q, s1_sat_d;
    logic               overflow_q, overflow_d;
    logic               pop;
    logic               drop;

    assign in_ext    = {{(32-IN_W){in_data[IN_W-1]}}, in_data};
    assign cond      = sat_shift(in_ext, SHIFT, OUT_W, RELU);
    assign unused_hi = ^cond.val[31:OUT_W];

    always_comb begin
        s1_valid_d = in_valid;
        s1_data_d  = s1_data_q;
        s1_sat_d   = s1_sat_q;
        if (in_valid) begin
            s1_data_d = cond.val[OUT_W-1:0];
            s1_sat_d  = cond.sat;
        end
    end

    always_comb begin
        pop        = out_valid && out_ready;
        drop       = s1_valid_q && full && !pop;
        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sat_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sat_q   <= s1_sat_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    sync_fifo_fwft #(
        .W     (OUT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid_q),
        .din   ({s1_sat_q, s1_data_q}),
        .pop   (out_ready),
        .dout  ({out_sat, out_data}),
        .valid (out_valid),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mac_result_buffer.sv
// Testbench for mac_result_buffer: directed steps plus a queue scoreboard.
// Honours MAC_RESULT_BUFFER_RELU_EN in its reference model.
module tb_mac_result_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [10:0] in_data;
    logic        out_ready;
    logic        out_valid, out_sat, full, empty, overflow;
    logic [7:0]  out_data;
    logic [2:0]  count;

    logic        out_valid2, out_sat2, full2, empty2, overflow2;
    logic [7:0]  out_data2;
    logic [2:0]  count2;

    int total = 0;
    int bad   = 0;

    logic [8:0] sq[$];
    logic       m_s1v = 1'b0;
    logic [8:0] m_s1e = '0;
    logic       m_ovf = 1'b0;
    logic       primed = 1'b0;

    always #5 clk = ~clk;

    mac_result_buffer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .count(count), .full(full), .empty(empty),
        .overflow(overflow)
    );

    mac_result_buffer #(.SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_sat(out_sat2), .count(count2), .full(full2), .empty(empty2),
        .overflow(overflow2)
    );

    function automatic logic [8:0] ref_res(input int x, input int sh);
        int s;
        s = x >>> sh;
`ifdef MAC_RESULT_BUFFER_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 127) return {1'b1, 8'h7f};
        if (s < -128) return {1'b1, 8'h80};
        return {1'b0, s[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        in_valid = 1'b1;
        in_data  = v[10:0];
        step();
        in_valid = 1'b0;
    endtask

    // Scoreboard: check DUT against model, then advance model to the next edge.
    initial begin
        int  x;
        logic mpop, mfull;
        forever begin
            @(negedge clk);
            if (primed) begin
                chk("sb_valid", 16'(out_valid), 16'(sq.size() != 0));
                chk("sb_count", 16'(count), 16'(sq.size()));
                chk("sb_ovf", 16'(overflow), 16'(m_ovf));
                if (sq.size() != 0) begin
                    chk("sb_data", 16'(out_data), 16'(sq[0][7:0]));
                    chk("sb_sat", 16'(out_sat), 16'(sq[0][8]));
                end
            end
            if (reset) begin
                sq.delete();
                m_s1v  = 1'b0;
                m_ovf  = 1'b0;
                primed = 1'b1;
            end else begin
                mpop  = (sq.size() != 0) && out_ready;
                mfull = (sq.size() == 4);
                if (mpop) void'(sq.pop_front());
                if (m_s1v) begin
                    if (!mfull || mpop) sq.push_back(m_s1e);
                    else m_ovf = 1'b1;
                end
                m_s1v = in_valid;
                x     = {{21{in_data[10]}}, in_data};
                m_s1e = ref_res(x, 0);
            end
        end
    end

    initial begin
        logic [8:0] e;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_count", 16'(count), 16'd0);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_full", 16'(full), 16'd0);
        chk("rst_ovf", 16'(overflow), 16'd0);
        chk("rst_sat", 16'(out_sat), 16'd0);
        chk("rst_data", 16'(out_data), 16'd0);

        // Single result with two-edge latency.
        pulse(100);
        chk("lat_early", 16'(out_valid), 16'd0);
        step();
        chk("lat_valid", 16'(out_valid), 16'd1);
        chk("lat_data", 16'(out_data), 16'd100);
        chk("lat_sat", 16'(out_sat), 16'd0);
        step();
        chk("lat_count", 16'(count), 16'd0);
        chk("lat_empty", 16'(empty), 16'd1);
        chk("lat_hold", 16'(out_data), 16'd100);

        // Saturation cases.
        pulse(300);
        step();
        e = ref_res(300, 0);
        chk("sat_p_data", 16'(out_data), 16'(e[7:0]));
        chk("sat_p_flag", 16'(out_sat), 16'(e[8]));
        chk("sh2_data", 16'(out_data2), 16'd75);
        chk("sh2_sat", 16'(out_sat2), 16'd0);
        step();
        pulse(-300);
        step();
        e = ref_res(-300, 0);
        chk("sat_n_data", 16'(out_data), 16'(e[7:0]));
        chk("sat_n_flag", 16'(out_sat), 16'(e[8]));
        step();
        pulse(-128);
        step();
        e = ref_res(-128, 0);
        chk("min_data", 16'(out_data), 16'(e[7:0]));
        chk("min_flag", 16'(out_sat), 16'(e[8]));
        step();
        pulse(-50);
        step();
        e = ref_res(-50, 0);
        chk("neg_data", 16'(out_data), 16'(e[7:0]));
        chk("neg_flag", 16'(out_sat), 16'(e[8]));
        step();
        pulse(200);
        step();
        chk("c200_data", 16'(out_data), 16'h7f);
        chk("c200_flag", 16'(out_sat), 16'd1);
        step();

        // Fill and overflow with back-to-back pulses.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) pulse(i);
        chk("fill_count", 16'(count), 16'd4);
        step();
        chk("ovf_count", 16'(count), 16'd4);
        chk("ovf_full", 16'(full), 16'd1);
        chk("ovf_flag", 16'(overflow), 16'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", 16'(out_data), 16'(i));
            step();
        end
        chk("drain_empty", 16'(empty), 16'd1);
        chk("ovf_sticky", 16'(overflow), 16'd1);

        // Full with simultaneous push and pop.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) pulse(i);
        in_valid = 1'b1;
        in_data  = 11'd9;
        step();
        in_valid  = 1'b0;
        chk("pp_full", 16'(full), 16'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pp_count", 16'(count), 16'd4);
        chk("pp_ovf", 16'(overflow), 16'd0);
        chk("pp_head", 16'(out_data), 16'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pp_last", 16'(out_data), 16'd9);
        chk("pp_empty", 16'(empty), 16'd1);

        // Reset with entries stored and one in flight.
        out_ready = 1'b0;
        pulse(5);
        pulse(6);
        pulse(7);
        pulse(8);
        chk("mid_count", 16'(count), 16'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_count", 16'(count), 16'd0);
        chk("mr_valid", 16'(out_valid), 16'd0);
        chk("mr_ovf", 16'(overflow), 16'd0);
        step();
        step();
        chk("mr_after", 16'(count), 16'd0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 11'($urandom_range(0, 2047));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("end_empty", 16'(empty), 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_result_buffer.md
Name: mac_result_buffer

Overview:
- Downstream stage of the MAC unit. Captures each 11-bit signed dot-product result on the MAC's single-cycle out_valid pulse.
- Each result is arithmetic-shifted right, then saturated to OUT_W bits with a per-entry saturation flag.
- Entries are held in a small first-word-fall-through FIFO and drained by the consumer over a valid/ready handshake.
- The MAC has no backpressure, so this block absorbs bursts and flags any loss.

Parameters:
- IN_W, 11, input result width; matches the MAC mac_out width.
- OUT_W, 8, stored/output signed width; must satisfy 2 <= OUT_W <= IN_W.
- SHIFT, 0, arithmetic right-shift applied before saturation; range 0..IN_W-1.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, result strobe; driven from the MAC out_valid.
- in_data, input, IN_W, signed result; driven from the MAC mac_out.
- out_valid, output, 1, FIFO head is valid.
- out_ready, input, 1, consumer accepts the head.
- out_data, output, OUT_W, signed head data.
- out_sat, output, 1, head entry was saturated.
- count, output, $clog2(DEPTH)+1, number of occupied entries.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- overflow, output, 1, sticky: a result was dropped.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: out_valid=0, count=0, empty=1, full=0, overflow=0, out_sat=0, out_data=0. Read/write pointers and the stage-1 valid are cleared.
- Stage 1 (conditioning), registered:
  - s = in_data >>> SHIFT, sign-extended.
  - If s > 2^(OUT_W-1)-1: d = max positive, sat = 1.
  - If s < -2^(OUT_W-1): d = min negative, sat = 1.
  - Otherwise: d = s[OUT_W-1:0], sat = 0.
  - s1_valid <= in_valid.
- Stage 2 (FIFO write): when s1_valid=1, push {sat, d} if there is room, else drop.
- Latency: in_valid sampled at edge N gives out_valid=1 with that data after edge N+1, when the FIFO was empty.
- Pop: occurs on a rising edge where out_valid && out_ready. out_data and out_sat always reflect the head entry; they show the last popped or reset value when empty.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - When full: the pop frees a slot and the push is accepted, with no overflow.
- Push when full without a pop:
  - The entry is discarded and overflow is set to 1.
  - overflow holds at 1 until reset.
  - count, data and pointers are unchanged.
- Pop when empty: impossible, because out_valid=0.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Back-to-back in_valid pulses, every cycle, are accepted at one per cycle.
- Reset mid-operation:
  - All entries are discarded and the stage-1 result in flight is squashed.
  - No push occurs on the cycle following reset deassertion unless in_valid was sampled while reset was low.
- in_data is ignored when in_valid=0.

Optional Feature:
- Macro: MAC_RESULT_BUFFER_RELU_EN.
- Defined: in stage 1, a negative s is replaced by 0 before saturation, so sat only ever flags positive clipping and out_data is never negative.
- Undefined: signed saturation only, as described in Behaviour.

Decomposition:
- Shared package mac_pkg:
  - MAC_IN_W = 11, MAC_OUT_W = 8.
  - Typedef mac_result_t, signed [10:0].
  - Typedef buf_entry_t, struct {sat, data}.
  - Function sat_shift(), the shift-and-saturate used by stage 1.
- One sub-module is natural: sync_fifo_fwft, a generic width/depth first-word-fall-through FIFO providing count/full/empty.
- mac_result_buffer instantiates sync_fifo_fwft and contains stage 1 plus the overflow logic.

Test Plan (defaults unless stated):
- Single result: in_data=100, one pulse, out_ready=1 -> out_valid after 2 edges, out_data=100, out_sat=0; count returns to 0.
- Saturation: 300 -> 127, out_sat=1. -300 -> -128, out_sat=1. -128 -> -128, out_sat=0. With SHIFT=2, 300 -> 75, out_sat=0.
- Fill and overflow: out_ready=0; five pulses of values 1..5 -> count=4, full=1, overflow=1. Draining yields 1,2,3,4; then empty=1 and overflow stays 1.
- Full with simultaneous push and pop: at count=4, pulse 9 with out_ready=1 -> pops 1, count stays 4, overflow=0, and 9 appears last.
- Reset mid-stream: 3 entries stored plus 1 in stage 1, then reset for one cycle -> count=0, out_valid=0, overflow=0; nothing appears afterwards.
- MAC_RESULT_BUFFER_RELU_EN defined: in_data=-50 -> out_data=0, out_sat=0. in_data=200 -> 127, out_sat=1.
